macc_seq: RTL
=============

# macc_seq

Loop sequencer for the MACC datapath. It computes C = A·B over power-of-two matrix dimensions by walking row, column and inner indices in the order i (outer), j (middle), k (inner). Each step issues one multiply-accumulate operation over a valid/ready handshake, carrying linearized A/B/C addresses and accumulator control flags. The block sits between the host command interface and the MAC array and operand memories.

## Interface
Parameters:
- MSB, 11, address MSB; all addresses are MSB+1 bits.
- LOG_W, 4, width of the log2 dimension inputs.

Ports:
- CLK  in  1  clock, rising edge.
- RST_L  in  1  reset, asynchronous, active-low.
- start  in  1  begin a job; honored only in IDLE.
- m_log2  in  LOG_W  log2 of rows of A and C; sampled when start is accepted.
- k_log2  in  LOG_W  log2 of the inner dimension; sampled when start is accepted.
- n_log2  in  LOG_W  log2 of columns of B and C; sampled when start is accepted.
- abort  in  1  cancel the running job. Present only with MACC_SEQ_ABORT_EN.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- op_valid  out  1  an operation is presented.
- op_ready  in  1  the MAC array accepts the operation.
- a_addr  out  MSB+1  A[i][k] = (i<<k_log2)|k.
- b_addr  out  MSB+1  B[k][j] = (k<<n_log2)|j.
- c_addr  out  MSB+1  C[i][j] = (i<<n_log2)|j.
- acc_clr  out  1  k==0; the MAC array clears its accumulator before this product.
- acc_last  out  1  k==K-1; the MAC array writes the accumulator to c_addr after this product.

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE:
  - On start, latch the three log2 inputs and zero i, j, k.
  - Go to ISSUE.
- ISSUE:
  - op_valid=1.
  - On op_valid&&op_ready, advance k. When k wraps from K-1 to 0, advance j. When j wraps from N-1 to 0, advance i.
  - On the handshake of the final operation (i=M-1, j=N-1, k=K-1), go to DONE.
- DONE:
  - done=1 for one cycle, then go to IDLE.
- Job size: exactly 2^(m_log2+n_log2+k_log2) handshakes.
- A log2 value of 0 means a dimension of 1. When k_log2=0, acc_clr and acc_last are both 1 on every operation.
- Address bits beyond MSB are truncated (modulo 2^(MSB+1)). Software keeps m+k, k+n and m+n ≤ MSB+1.
- Outputs are stable while op_valid=1 and op_ready=0. Addresses and flags change only after a handshake.
- start is ignored in ISSUE and DONE. Dimension inputs are ignored outside the accept cycle.
- op_ready is ignored when op_valid=0.

## Timing
- Reset values: busy=0, done=0, op_valid=0, a_addr=b_addr=c_addr=0, acc_clr=0, acc_last=0. State=IDLE.
- All outputs are registered. There is no combinational path from op_ready or start to any output.
- start is sampled at edge 0. At cycle 1: busy=1, op_valid=1, first operation presented with acc_clr=1.
- With op_ready held high: one operation per cycle over cycles 1..T, where T=2^(m+n+k).
- At cycle T+1: done=1, busy=0, op_valid=0.
- start asserted in the DONE cycle is ignored. The earliest new accept is cycle T+2.
- An RST_L assertion at any time forces the reset values immediately. The in-flight operation is dropped.

## Configuration
- MACC_SEQ_ABORT_EN defined:
  - The abort port exists.
  - abort=1 in ISSUE, sampled at a clock edge, forces op_valid=0 at that edge and goes to DONE. This takes priority over a simultaneous handshake; that handshake is still counted as accepted by the MAC array.
  - done pulses as for normal completion.
  - abort is ignored in IDLE and DONE.
- MACC_SEQ_ABORT_EN undefined: the port is absent and jobs always run to completion.

## Structure
- Package macc_pkg holds:
  - the state enum macc_seq_state_t (IDLE, ISSUE, DONE);
  - localparam LOG_W_DEF=4;
  - the address-composition function.
- The natural sub-module is macc_loop_ctr: a wrap counter with a log2 limit and increment-enable, carry-out on wrap, and asynchronous active-low reset. macc_seq instantiates it three times, for k, j and i, chained by carry-out.

## Test plan
- Reset mid-job: drop RST_L during operation 3 of a 2×2×2 job. All outputs go to 0 immediately. After release the block is in IDLE and a new start behaves normally.
- m=n=k log2=1, op_ready=1: exactly 8 operations.
  - a_addr sequence: 0,1,0,1,2,3,2,3.
  - b_addr sequence: 0,2,1,3,0,2,1,3.
  - c_addr sequence: 0,0,1,1,2,2,3,3.
  - done occurs at cycle 9.
- Back-pressure: same job, op_ready toggling 1,0,0,1. Outputs hold while stalled. There are exactly 8 handshakes and no skipped or duplicated addresses.
- k_log2=0, m=2, n=1 log2: 8 operations. acc_clr=acc_last=1 on every operation. c_addr runs 0..7.
- start pulsed during ISSUE and in the DONE cycle: both ignored. No second job starts until a start in IDLE.
- With MACC_SEQ_ABORT_EN: abort at operation 5 of 8. op_valid drops at the next edge, done pulses once, and the block returns to IDLE.

Source files
------------

// File: rtl/macc_pkg.sv
// Shared types and helpers for the MACC loop sequencer.
// Holds the FSM state enum, default dimension-field width and address composition.
package macc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } macc_seq_state_t;

    localparam int LOG_W_DEF = 4;

    // Linearized address: high index shifted past the low index field.
    function automatic logic [31:0] compose_addr(input logic [31:0] hi,
                                                 input logic [31:0] lo,
                                                 input logic [7:0]  sh);
        return (hi << sh) | lo;
    endfunction

endpackage

// File: rtl/macc_loop_ctr.sv
// Wrap counter 0..2^lim_log2-1 with increment enable; wrap is the carry-out on the last step.
// Latency: count updates one cycle after en; wrap is combinational from en and the count.
module macc_loop_ctr #(
    parameter int W     = 12,
    parameter int LOG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [LOG_W-1:0] lim_log2,
    output logic [W-1:0]     cnt,
    output logic             wrap
);

    logic [W-1:0] last_val;

    assign last_val = ~({W{1'b1}} << lim_log2);
    assign wrap     = en && (cnt == last_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/macc_seq.sv
// Loop sequencer for C = A*B: walks i/j/k and issues one MAC op per valid/ready handshake.
// Outputs decode only registered state; op holds while op_ready is low. Optional abort: MACC_SEQ_ABORT_EN.
module macc_seq
    import macc_pkg::*;
#(
    parameter int MSB   = 11,
    parameter int LOG_W = LOG_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_L,
    input  logic             start,
    input  logic [LOG_W-1:0] m_log2,
    input  logic [LOG_W-1:0] k_log2,
    input  logic [LOG_W-1:0] n_log2,
`ifdef MACC_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [MSB:0]     a_addr,
    output logic [MSB:0]     b_addr,
    output logic [MSB:0]     c_addr,
    output logic             acc_clr,
    output logic             acc_last
);

    localparam int AW = MSB + 1;

    macc_seq_state_t  state, nxt_state;
    logic [LOG_W-1:0] m_l, k_l, n_l;
    logic [AW-1:0]    i_cnt, j_cnt, k_cnt, k_max;
    logic             i_wrap, j_wrap, k_wrap;
    logic             accept, hs, abort_hit;

    assign accept = (state == IDLE) && start;
    assign hs     = (state == ISSUE) && op_ready;

`ifdef MACC_SEQ_ABORT_EN
    assign abort_hit = (state == ISSUE) && abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state <= IDLE;
            m_l   <= '0;
            k_l   <= '0;
            n_l   <= '0;
        end else begin
            state <= nxt_state;
            if (accept) begin
                m_l <= m_log2;
                k_l <= k_log2;
                n_l <= n_log2;
            end
        end
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (start) nxt_state = ISSUE;
            // Abort wins over a simultaneous final handshake; both end in DONE.
            ISSUE:   if (abort_hit || i_wrap) nxt_state = DONE;
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    macc_loop_ctr #(.W(AW), .LOG_W(LOG_W)) u_k_ctr (
        .clk(CLK), .rst_n(RST_L), .clr(accept), .en(hs),
        .lim_log2(k_l), .cnt(k_cnt), .wrap(k_wrap)
    );

    macc_loop_ctr #(.W(AW), .LOG_W(LOG_W)) u_j_ctr (
        .clk(CLK), .rst_n(RST_L), .clr(accept), .en(k_wrap),
        .lim_log2(n_l), .cnt(j_cnt), .wrap(j_wrap)
    );

    macc_loop_ctr #(.W(AW), .LOG_W(LOG_W)) u_i_ctr (
        .clk(CLK), .rst_n(RST_L), .clr(accept), .en(j_wrap),
        .lim_log2(m_l), .cnt(i_cnt), .wrap(i_wrap)
    );

    assign k_max = ~({AW{1'b1}} << k_l);

    assign busy     = (state == ISSUE);
    assign op_valid = (state == ISSUE);
    assign done     = (state == DONE);
    assign acc_clr  = (state == ISSUE) && (k_cnt == '0);
    assign acc_last = (state == ISSUE) && (k_cnt == k_max);

    // Bits above MSB fall off in the truncating cast.
    assign a_addr = AW'(compose_addr(32'(i_cnt), 32'(k_cnt), 8'(k_l)));
    assign b_addr = AW'(compose_addr(32'(k_cnt), 32'(j_cnt), 8'(n_l)));
    assign c_addr = AW'(compose_addr(32'(i_cnt), 32'(j_cnt), 8'(n_l)));

endmodule
